zap_shifter_pipe: RTL and testbench

Pipeline register stage between the barrel-shift datapath and the ALU. It captures each shifted operand and its carry, saturation flag and destination tag, then presents them to the ALU with a valid/ready handshake. It absorbs ALU back-pressure without losing data, honours pipeline flushes, and accumulates a sticky saturation (Q) indication for the ALU flag logic.

---
 rtl/zap_shifter_pipe_pkg.sv | 20 ++
 rtl/zap_shifter_pipe_skid.sv | 62 ++++++
 rtl/zap_shifter_pipe.sv | 86 ++++++++
 tb/tb_zap_shifter_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_shifter_pipe_pkg.sv
// Shared types for the shifter-to-ALU pipeline register stage.
// Holds the control state enum and the packed payload bundle.
package zap_shifter_pipe_pkg;

    localparam int TAG_W_C = 6;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_e;

    typedef struct packed {
        logic [31:0]        result;
        logic               carry;
        logic               sat;
        logic [TAG_W_C-1:0] tag;
    } payload_t;

endpackage

// File: rtl/zap_shifter_pipe_skid.sv
// Generic 2-entry skid buffer over the packed payload.
// o_ready is a pure decode of registered state (no path from i_ready).
module zap_shifter_pipe_skid
    import zap_shifter_pipe_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset_n,
    input  logic     i_clear,
    input  logic     i_valid,
    output logic     o_ready,
    input  payload_t i_data,
    output logic     o_valid,
    input  logic     i_ready,
    output payload_t o_data
);

    state_e   r_state;
    payload_t r_main;
    payload_t r_skid;
    logic     w_acc;
    logic     w_hs;

    assign o_ready = (r_state != ST_FULL);
    assign o_valid = (r_state != ST_EMPTY);
    assign o_data  = r_main;
    assign w_acc   = i_valid && o_ready && !i_clear;
    assign w_hs    = o_valid && i_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_EMPTY;
        end else if (i_clear) begin
            r_state <= ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: if (w_acc) r_state <= ST_ONE;
                ST_ONE: begin
                    if (w_acc && !w_hs)      r_state <= ST_FULL;
                    else if (w_hs && !w_acc) r_state <= ST_EMPTY;
                end
                ST_FULL:  if (w_hs) r_state <= ST_ONE;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    // Main is zeroed at reset so the idle outputs read as zero.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_main <= '0;
        end else if (r_state == ST_FULL) begin
            if (w_hs && !i_clear) r_main <= r_skid;
        end else if (w_acc && (r_state == ST_EMPTY || w_hs)) begin
            r_main <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_acc && (r_state == ST_ONE) && !w_hs) r_skid <= i_data;
    end

endmodule

// File: rtl/zap_shifter_pipe.sv
// Shifter-to-ALU pipeline register with sticky saturation (Q) flag.
// Define ZAP_SHIFT_PIPE_SKID_EN for the 2-entry skid buffer variant.
module zap_shifter_pipe
    import zap_shifter_pipe_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_result,
    input  logic             i_carry,
    input  logic             i_sat,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_result,
    output logic             o_carry,
    output logic             o_sat,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_sat_sticky,
    input  logic             i_sat_clr
);

    payload_t w_in;
    payload_t w_out;
    logic     r_sat_sticky;

    assign w_in.result = i_result;
    assign w_in.carry  = i_carry;
    assign w_in.sat    = i_sat;
    assign w_in.tag    = i_tag;

`ifdef ZAP_SHIFT_PIPE_SKID_EN
    zap_shifter_pipe_skid u_skid (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (i_clear),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (w_in),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (w_out)
    );
`else
    state_e   r_state;
    payload_t r_data;
    logic     w_acc;

    assign o_valid = (r_state == ST_ONE);
    assign o_ready = !o_valid || i_ready;
    assign w_out   = r_data;
    assign w_acc   = i_valid && o_ready && !i_clear;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
        end else if (i_clear) begin
            r_state <= ST_EMPTY;
        end else if (w_acc) begin
            r_state <= ST_ONE;
            r_data  <= w_in;
        end else if (o_valid && i_ready) begin
            r_state <= ST_EMPTY;
        end
    end
`endif

    assign o_result     = w_out.result;
    assign o_carry      = w_out.carry;
    assign o_sat        = w_out.sat;
    assign o_tag        = w_out.tag;
    assign o_sat_sticky = r_sat_sticky;

    // Consumption counts even during a flush; set beats clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)                      r_sat_sticky <= 1'b0;
        else if (o_valid && i_ready && o_sat) r_sat_sticky <= 1'b1;
        else if (i_sat_clr)                  r_sat_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_zap_shifter_pipe.sv
// Self-checking bench for zap_shifter_pipe (queue model + directed vectors).
module tb_zap_shifter_pipe;
    import zap_shifter_pipe_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_clear;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_result;
    logic        i_carry;
    logic        i_sat;
    logic [5:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_carry;
    logic        o_sat;
    logic [5:0]  o_tag;
    logic        o_sat_sticky;
    logic        i_sat_clr;

    int n_chk  = 0;
    int n_fail = 0;

    payload_t q[$];
    payload_t m_e;
    logic     m_sticky = 1'b0;
    logic     m_hs;
    logic     m_acc;

    zap_shifter_pipe #(.TAG_W(6)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_clear      (i_clear),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_result     (i_result),
        .i_carry      (i_carry),
        .i_sat        (i_sat),
        .i_tag        (i_tag),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_result     (o_result),
        .o_carry      (o_carry),
        .o_sat        (o_sat),
        .o_tag        (o_tag),
        .o_sat_sticky (o_sat_sticky),
        .i_sat_clr    (i_sat_clr)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic m_ready();
`ifdef ZAP_SHIFT_PIPE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || i_ready;
`endif
    endfunction

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: FIFO of entries the stage currently holds.
    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            q.delete();
            m_sticky = 1'b0;
        end else begin
            m_hs  = (q.size() != 0) && i_ready;
            m_acc = i_valid && m_ready() && !i_clear;
            if (m_hs && q[0].sat) m_sticky = 1'b1;
            else if (i_sat_clr)   m_sticky = 1'b0;
            if (m_hs) void'(q.pop_front());
            if (i_clear) begin
                q.delete();
            end else if (m_acc) begin
                m_e.result = i_result;
                m_e.carry  = i_carry;
                m_e.sat    = i_sat;
                m_e.tag    = i_tag;
                q.push_back(m_e);
            end
        end
    end

    always @(negedge i_clk) begin
        chk("o_valid", 64'(o_valid), 64'(q.size() != 0));
        chk("o_ready", 64'(o_ready), 64'(m_ready()));
        chk("o_sat_sticky", 64'(o_sat_sticky), 64'(m_sticky));
        if (q.size() != 0)
            chk("payload", 64'({o_result, o_carry, o_sat, o_tag}), 64'(q[0]));
    end

    task automatic drive(logic v, logic r, logic [31:0] d, logic s);
        i_valid  = v;
        i_ready  = r;
        i_result = d;
        i_carry  = d[0];
        i_sat    = s;
        i_tag    = d[5:0];
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic async_reset();
        #2 i_reset_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(o_valid), 64'd0);
        chk("rst_async_ready", 64'(o_ready), 64'd1);
        @(negedge i_clk);
        #1 i_reset_n = 1'b1;
        step();
        step();
        chk("post_rst_valid", 64'(o_valid), 64'd0);
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_clear   = 1'b0;
        i_sat_clr = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_sticky", 64'(o_sat_sticky), 64'd0);
        chk("rst_payload", 64'({o_result, o_carry, o_sat, o_tag}), 64'd0);
        @(negedge i_clk);
        #1 i_reset_n = 1'b1;
        step();

        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b1, 32'(k), 1'b0);
            step();
            chk("stream_valid", 64'(o_valid), 64'd1);
            chk("stream_result", 64'(o_result), 64'(k));
            chk("stream_ready", 64'(o_ready), 64'd1);
        end
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        step();
        chk("stream_drain", 64'(o_valid), 64'd0);

        drive(1'b1, 1'b1, 32'h7FFFFFFF, 1'b1);
        step();
        chk("sat_out", 64'(o_sat), 64'd1);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        step();
        chk("sticky_set", 64'(o_sat_sticky), 64'd1);
        drive(1'b1, 1'b1, 32'h7FFFFFFF, 1'b1);
        step();
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        i_sat_clr = 1'b1;
        step();
        chk("sticky_set_wins", 64'(o_sat_sticky), 64'd1);
        step();
        chk("sticky_clr", 64'(o_sat_sticky), 64'd0);
        i_sat_clr = 1'b0;

`ifdef ZAP_SHIFT_PIPE_SKID_EN
        drive(1'b1, 1'b0, 32'hA, 1'b0);
        step();
        chk("stall_a", 64'(o_result), 64'hA);
        chk("stall_ready1", 64'(o_ready), 64'd1);
        drive(1'b1, 1'b0, 32'hB, 1'b0);
        step();
        chk("stall_full", 64'(o_ready), 64'd0);
        chk("stall_hold_a", 64'(o_result), 64'hA);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        step();
        chk("skid_b", 64'(o_result), 64'hB);
        chk("skid_ready", 64'(o_ready), 64'd1);
        step();
        chk("skid_empty", 64'(o_valid), 64'd0);

        drive(1'b1, 1'b0, 32'hD, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'hE, 1'b0);
        step();
        chk("flush_full", 64'(o_ready), 64'd0);
        drive(1'b1, 1'b0, 32'hC, 1'b0);
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        chk("flush_valid", 64'(o_valid), 64'd0);
        chk("flush_ready", 64'(o_ready), 64'd1);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        step();
        chk("flush_no_c", 64'(o_valid), 64'd0);

        drive(1'b1, 1'b0, 32'h21, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h22, 1'b0);
        step();
        chk("pre_rst_full", 64'(o_ready), 64'd0);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        async_reset();
`else
        drive(1'b1, 1'b1, 32'h10, 1'b0);
        step();
        chk("tog_first", 64'(o_result), 64'h10);
        drive(1'b1, 1'b0, 32'h11, 1'b0);
        #1;
        chk("tog_ready_lo", 64'(o_ready), 64'd0);
        step();
        chk("tog_hold", 64'(o_result), 64'h10);
        i_ready = 1'b1;
        #1;
        chk("tog_ready_hi", 64'(o_ready), 64'd1);
        step();
        chk("tog_second", 64'(o_result), 64'h11);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        step();
        chk("tog_drain", 64'(o_valid), 64'd0);

        drive(1'b1, 1'b0, 32'h30, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'hC, 1'b0);
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        chk("flush_valid", 64'(o_valid), 64'd0);
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        step();
        chk("flush_no_c", 64'(o_valid), 64'd0);

        drive(1'b1, 1'b0, 32'h31, 1'b0);
        step();
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        async_reset();
`endif
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
